// File: rtl/yarvi_wb_pkg.sv
// Shared definitions for the write-back scheduler: register-file geometry,
// scheduler state encoding and a one-hot decode helper.
package yarvi_wb_pkg;

  localparam int REG_W = 5;
  localparam int NREGS = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } sched_state_e;

  // Decode a register index into a 32-bit one-hot mask.
  function automatic logic [NREGS-1:0] onehot5(input logic [REG_W-1:0] idx);
    logic [NREGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/yarvi_scoreboard.sv
// Busy scoreboard of destinations still owed by the long-latency unit.
// One set port (issue) and one clear port (accept); set wins on collision.
// x0 is never marked busy.
// Build option YARVI_WB_EARLY_CLEAR_EN: lookups ignore the entry being
// cleared this cycle, so a waiting consumer issues alongside the accept.
module yarvi_scoreboard
  import yarvi_wb_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_idx,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_idx,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_busy_rs1,
  output logic             o_busy_rs2,
  output logic             o_busy_rd
);

  localparam logic [NREGS-1:0] X0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_view;

  assign w_set_mask = i_set_en ? onehot5(i_set_idx) : '0;
  assign w_clr_mask = i_clr_en ? onehot5(i_clr_idx) : '0;

`ifdef YARVI_WB_EARLY_CLEAR_EN
  assign w_view = r_busy & ~w_clr_mask;
`else
  assign w_view = r_busy;
`endif

  assign o_busy_rs1 = w_view[i_rs1];
  assign o_busy_rs2 = w_view[i_rs2];
  assign o_busy_rd  = w_view[i_rd];

  // Clear first, then set, so a same-index set overrides the clear; bit 0 stays low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & X0_MASK;
    end
  end

endmodule

// File: rtl/yarvi_wb_sched.sv
// Register-file write-port scheduler. The fixed-timing ALU always owns the
// port when it has a result; the long-latency unit is served through a
// valid/ready handshake otherwise. Tracks pending long-latency destinations,
// stalls issue on RAW/WAW and pending-limit hazards, and enters a drain state
// that blocks issue when the long-latency unit has been refused too long.
// Build option YARVI_WB_EARLY_CLEAR_EN (see yarvi_scoreboard).
module yarvi_wb_sched
  import yarvi_wb_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int MAX_PENDING  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_long,
  output logic             issue_stall,
  input  logic             alu_valid,
  input  logic [REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_val,
  input  logic             lu_valid,
  input  logic [REG_W-1:0] lu_rd,
  input  logic [XLEN-1:0]  lu_val,
  output logic             lu_ready,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_val
);

  localparam logic [2:0] PEND_MAX    = 3'(MAX_PENDING);
  localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

  sched_state_e     r_state;
  logic [2:0]       r_pend_cnt;
  logic [7:0]       r_starve_cnt;
  logic [REG_W-1:0] r_wb_rd;
  logic [XLEN-1:0]  r_wb_val;

  logic w_lu_ready;
  logic w_accept;
  logic w_refuse;
  logic w_busy_rs1;
  logic w_busy_rs2;
  logic w_busy_rd;
  logic w_hazard;
  logic w_stall;
  logic w_issue_long;
  logic w_set_en;

  // ALU has absolute priority; nothing is accepted while in reset.
  assign w_lu_ready = reset_n & ~alu_valid;
  assign w_accept   = lu_valid & w_lu_ready;
  assign w_refuse   = lu_valid & ~w_lu_ready;

  assign w_hazard = w_busy_rs1 | w_busy_rs2 | w_busy_rd |
                    (issue_long & (r_pend_cnt == PEND_MAX)) |
                    (r_state == DRAIN);
  assign w_stall      = ~reset_n | (issue_valid & w_hazard);
  assign w_issue_long = issue_valid & ~w_stall & issue_long;
  assign w_set_en     = w_issue_long & (issue_rd != '0);

  assign issue_stall = w_stall;
  assign lu_ready    = w_lu_ready;
  assign wb_rd       = r_wb_rd;
  assign wb_val      = r_wb_val;

  yarvi_scoreboard u_sb (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_set_en   (w_set_en),
    .i_set_idx  (issue_rd),
    .i_clr_en   (w_accept),
    .i_clr_idx  (lu_rd),
    .i_rs1      (issue_rs1),
    .i_rs2      (issue_rs2),
    .i_rd       (issue_rd),
    .o_busy_rs1 (w_busy_rs1),
    .o_busy_rs2 (w_busy_rs2),
    .o_busy_rd  (w_busy_rd)
  );

  // Write-back register: ALU result, else accepted long result, else no write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_rd  <= '0;
      r_wb_val <= '0;
    end else if (alu_valid) begin
      r_wb_rd  <= alu_rd;
      r_wb_val <= alu_val;
    end else if (w_accept) begin
      r_wb_rd  <= lu_rd;
      r_wb_val <= lu_val;
    end else begin
      r_wb_rd  <= '0;
    end
  end

  // Count of long ops in flight; saturates at both ends instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_cnt <= '0;
    end else if (w_issue_long && !w_accept) begin
      if (r_pend_cnt != 3'd7) r_pend_cnt <= r_pend_cnt + 3'd1;
    end else if (w_accept && !w_issue_long) begin
      if (r_pend_cnt != 3'd0) r_pend_cnt <= r_pend_cnt - 3'd1;
    end
  end

  // Starvation FSM: count consecutive refusals, drain until the next accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        NORMAL: begin
          if (w_refuse) begin
            if (r_starve_cnt != 8'hFF) r_starve_cnt <= r_starve_cnt + 8'd1;
            if (r_starve_cnt == STARVE_LAST) r_state <= DRAIN;
          end else begin
            r_starve_cnt <= '0;
          end
        end
        DRAIN: begin
          if (w_accept) begin
            r_state      <= NORMAL;
            r_starve_cnt <= '0;
          end
        end
        default: r_state <= NORMAL;
      endcase
    end
  end

  // An accept with nothing pending means the long-latency unit broke protocol.
  a_no_orphan_accept: assert property (@(posedge clock) disable iff (!reset_n)
    !(w_accept && (r_pend_cnt == 3'd0)));

endmodule

// File: tb/tb_yarvi_wb_sched.sv
module tb_yarvi_wb_sched;

`ifdef YARVI_WB_EARLY_CLEAR_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_long;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_val;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [63:0] lu_val;
  logic        lu_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_val;

  int n_tests;
  int n_fail;

  yarvi_wb_sched #(.XLEN(64), .MAX_PENDING(2), .STARVE_LIMIT(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_long  (issue_long),
    .issue_stall (issue_stall),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_val     (alu_val),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_val      (lu_val),
    .lu_ready    (lu_ready),
    .wb_rd       (wb_rd),
    .wb_val      (wb_val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        il;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] aval;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] lval;
    logic        e_ready;
    logic        e_stall;
    logic [4:0]  e_wbrd;
    logic [63:0] e_wbval;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input int iv, input int rs1, input int rs2, input int rd,
                              input int il, input int av, input int ard, input int aval,
                              input int lv, input int lrd, input int lval,
                              input int e_ready, input int e_stall, input int e_wbrd,
                              input int e_wbval);
    vec_t v;
    v.iv = 1'(iv); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.il = 1'(il);
    v.av = 1'(av); v.ard = 5'(ard); v.aval = 64'(unsigned'(aval));
    v.lv = 1'(lv); v.lrd = 5'(lrd); v.lval = 64'(unsigned'(lval));
    v.e_ready = 1'(e_ready); v.e_stall = 1'(e_stall);
    v.e_wbrd = 5'(e_wbrd); v.e_wbval = 64'(unsigned'(e_wbval));
    return v;
  endfunction

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int iv, input int rs1, input int rs2, input int rd, input int il,
                       input int av, input int ard, input int aval,
                       input int lv, input int lrd, input int lval);
    issue_valid = 1'(iv); issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2);
    issue_rd = 5'(rd); issue_long = 1'(il);
    alu_valid = 1'(av); alu_rd = 5'(ard); alu_val = 64'(unsigned'(aval));
    lu_valid = 1'(lv); lu_rd = 5'(lrd); lu_val = 64'(unsigned'(lval));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // table: ALU write-back, RAW release, arbitration, pending limit, WAW/RAW rs2
    tbl[0]  = mk(0, 0, 0, 0, 0,  1, 5, 'h1234,  0, 0, 0,      0, 0, 5, 'h1234);
    tbl[1]  = mk(0, 0, 0, 0, 0,  1, 0, 'hABCD,  0, 0, 0,      0, 0, 0, 'hABCD);
    tbl[2]  = mk(0, 0, 0, 0, 0,  0, 0, 0,       0, 0, 0,      1, 0, 0, 'hABCD);
    tbl[3]  = mk(1, 1, 2, 7, 1,  0, 0, 0,       0, 0, 0,      1, 0, 0, 'hABCD);
    tbl[4]  = mk(1, 7, 0, 8, 0,  0, 0, 0,       0, 0, 0,      1, 1, 0, 'hABCD);
    tbl[5]  = mk(1, 7, 0, 8, 0,  0, 0, 0,       1, 7, 'h77,   1, EARLY ? 0 : 1, 7, 'h77);
    tbl[6]  = mk(1, 7, 0, 8, 0,  0, 0, 0,       0, 0, 0,      1, 0, 0, 'h77);
    tbl[7]  = mk(1, 0, 0, 9, 1,  0, 0, 0,       0, 0, 0,      1, 0, 0, 'h77);
    tbl[8]  = mk(0, 0, 0, 0, 0,  1, 2, 'h22,    1, 9, 'h99,   0, 0, 2, 'h22);
    tbl[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0,       1, 9, 'h99,   1, 0, 9, 'h99);
    tbl[10] = mk(1, 0, 0, 3, 1,  0, 0, 0,       0, 0, 0,      1, 0, 0, 'h99);
    tbl[11] = mk(1, 0, 0, 4, 1,  0, 0, 0,       0, 0, 0,      1, 0, 0, 'h99);
    tbl[12] = mk(1, 0, 0, 5, 1,  0, 0, 0,       0, 0, 0,      1, 1, 0, 'h99);
    tbl[13] = mk(1, 1, 2, 6, 0,  0, 0, 0,       0, 0, 0,      1, 0, 0, 'h99);
    tbl[14] = mk(0, 0, 0, 0, 0,  0, 0, 0,       1, 3, 'h33,   1, 0, 3, 'h33);
    tbl[15] = mk(1, 0, 0, 10, 1, 0, 0, 0,       1, 4, 'h44,   1, 0, 4, 'h44);
    tbl[16] = mk(1, 0, 0, 11, 1, 0, 0, 0,       0, 0, 0,      1, 0, 0, 'h44);
    tbl[17] = mk(1, 0, 0, 12, 1, 0, 0, 0,       0, 0, 0,      1, 1, 0, 'h44);
    tbl[18] = mk(1, 0, 0, 10, 0, 0, 0, 0,       0, 0, 0,      1, 1, 0, 'h44);
    tbl[19] = mk(1, 0, 11, 1, 0, 0, 0, 0,       0, 0, 0,      1, 1, 0, 'h44);
    tbl[20] = mk(0, 0, 0, 0, 0,  0, 0, 0,       1, 10, 'hA0,  1, 0, 10, 'hA0);
    tbl[21] = mk(0, 0, 0, 0, 0,  0, 0, 0,       1, 11, 'hB0,  1, 0, 11, 'hB0);

    // reset state
    step();
    step();
    chk_v("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk_v("rst_wb_val", wb_val, 64'd0);
    chk_b("rst_lu_ready", lu_ready, 1'b0);
    chk_b("rst_issue_stall", issue_stall, 1'b1);
    reset_n = 1'b1;
    #1;
    chk_b("post_rst_stall", issue_stall, 1'b0);
    step();

    for (int i = 0; i < 22; i++) begin
      drive(int'(tbl[i].iv), int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd),
            int'(tbl[i].il), int'(tbl[i].av), int'(tbl[i].ard), int'(tbl[i].aval[31:0]),
            int'(tbl[i].lv), int'(tbl[i].lrd), int'(tbl[i].lval[31:0]));
      #2;
      chk_b($sformatf("v%0d_lu_ready", i), lu_ready, tbl[i].e_ready);
      chk_b($sformatf("v%0d_stall", i), issue_stall, tbl[i].e_stall);
      step();
      chk_v($sformatf("v%0d_wb_rd", i), 64'(wb_rd), 64'(tbl[i].e_wbrd));
      chk_v($sformatf("v%0d_wb_val", i), wb_val, tbl[i].e_wbval);
    end

    // starvation: 8 refusals enter DRAIN, first accept returns to NORMAL
    drive(1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0);
    #2 chk_b("drn_setup_stall", issue_stall, 1'b0);
    step();
    for (int c = 0; c < 8; c++) begin
      drive(1, 0, 0, 14, 0, 1, 0, c, 1, 13, 'hD0);
      #2;
      chk_b($sformatf("drn_refuse%0d_stall", c), issue_stall, 1'b0);
      chk_b($sformatf("drn_refuse%0d_ready", c), lu_ready, 1'b0);
      step();
    end
    drive(1, 0, 0, 14, 0, 1, 0, 9, 1, 13, 'hD0);
    #2 chk_b("drn_entered_stall", issue_stall, 1'b1);
    step();
    drive(1, 0, 0, 14, 0, 0, 0, 0, 1, 13, 'hD0);
    #2;
    chk_b("drn_accept_ready", lu_ready, 1'b1);
    chk_b("drn_accept_stall", issue_stall, 1'b1);
    step();
    chk_v("drn_wb_rd", 64'(wb_rd), 64'd13);
    chk_v("drn_wb_val", wb_val, 64'hD0);
    drive(1, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0);
    #2 chk_b("drn_exit_stall", issue_stall, 1'b0);
    step();
    for (int c = 0; c < 7; c++) begin
      drive(1, 0, 0, 14, 0, 1, 0, 0, 1, 15, 'hF0);
      #2 chk_b($sformatf("starve_reset%0d_stall", c), issue_stall, 1'b0);
      step();
    end
    drive(1, 0, 0, 14, 0, 0, 0, 0, 1, 15, 'hF0);
    #2 chk_b("starve_reset_final_stall", issue_stall, 1'b0);
    step();
    chk_v("starve_reset_wb_rd", 64'(wb_rd), 64'd15);

    // long op to x0 counts as pending but marks nothing busy; then async reset
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    #2 chk_b("x0_long_stall", issue_stall, 1'b0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk_b("x0_not_busy", issue_stall, 1'b0);
    step();
    drive(1, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0);
    #2 chk_b("second_long_stall", issue_stall, 1'b0);
    step();
    drive(1, 0, 0, 17, 1, 1, 20, 'h55, 0, 0, 0);
    #2 chk_b("pend_full_stall", issue_stall, 1'b1);
    step();
    chk_v("pre_rst_wb_rd", 64'(wb_rd), 64'd20);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    chk_v("async_rst_wb_rd", 64'(wb_rd), 64'd0);
    chk_v("async_rst_wb_val", wb_val, 64'd0);
    chk_b("async_rst_ready", lu_ready, 1'b0);
    chk_b("async_rst_stall", issue_stall, 1'b1);
    step();
    reset_n = 1'b1;
    drive(1, 16, 0, 18, 0, 0, 0, 0, 0, 0, 0);
    #2 chk_b("rst_cleared_busy", issue_stall, 1'b0);
    step();
    drive(1, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0);
    #2 chk_b("rst_pend_a", issue_stall, 1'b0);
    step();
    drive(1, 0, 0, 17, 1, 0, 0, 0, 0, 0, 0);
    #2 chk_b("rst_pend_b", issue_stall, 1'b0);
    step();
    drive(1, 0, 0, 18, 1, 0, 0, 0, 0, 0, 0);
    #2 chk_b("rst_pend_full", issue_stall, 1'b1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
